arb_mux: RTL and testbench
==========================

// Module: arb_mux
// PURPOSE
//  N-channel, WIDTH-bit registered multiplexer with valid/ready handshake and built-in arbitration.
//  Next-generation replacement for the fixed 3:1 combinational select muxes in the cpu datapath,
//  where several producers (e.g. forwarding paths, memory/IO return ports) contend for one consumer.
//  Selects one requesting channel per cycle, by fixed priority or round-robin.
//  Registers the winner into a one-entry output stage.
// PARAMETERS
//  WIDTH    8  data bits per channel
//  N        3  number of input channels, 2..16
//  RR_MODE  1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  in_valid   in   N          channel i has data
//  in_data    in   N*WIDTH    channel i data in bits [i*WIDTH +: WIDTH]
//  in_last    in   N          channel i final beat of burst; used only with ARB_MUX_LOCK_EN
//  in_ready   out  N          channel i beat accepted this cycle (one-hot or zero)
//  out_valid  out  1          output register holds data
//  out_data   out  WIDTH      registered data
//  out_sel    out  SEL_W      index of channel that supplied out_data; SEL_W = max(1,$clog2(N))
//  out_ready  in   1          consumer accepts out_data
// BEHAVIOUR
//  - Reset, async and immediate: out_valid=0, out_data=0, out_sel=0, rr_ptr=0, lock cleared.
//    in_ready=0 while reset is asserted.
//  - load = !out_valid | out_ready. Arbitration evaluates only when load=1.
//    When load=0, all in_ready=0 and the output register holds its value.
//  - Grant (combinational), fixed mode: lowest i with in_valid[i].
//    Round-robin mode: first i with in_valid[i], searching from rr_ptr upward, wrapping N-1 -> 0.
//  - Transfer: in_ready[g]=1 iff load and a grant exists.
//    On the next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1.
//  - Latency 1 cycle. Throughput 1 beat/cycle.
//  - Output update: if load and no grant, out_valid<=0. Data and sel keep their last values.
//  - rr_ptr <= (g==N-1) ? 0 : g+1, only on a transfer. rr_ptr is unused when RR_MODE=0.
//  - Simultaneous out_ready and new grant: old beat leaves and new beat enters in the same edge.
//    No bubble.
//  - Handshake: in_ready never depends on in_ready of another cycle.
//    A channel must hold in_valid/in_data until it sees in_ready.
//  - Output stage state: EMPTY (out_valid=0) / FULL (out_valid=1).
//    EMPTY->FULL on grant. FULL->EMPTY on out_ready with no grant.
//    FULL->FULL on stall, or on out_ready with a grant.
//  - Mid-operation reset drops the held beat and any lock. No partial state survives.
// CONFIGURATION
//  ARB_MUX_LOCK_EN defined:
//   - LOCKED state: after a transfer from channel g with in_last[g]=0, the grant is forced to g.
//     Other channels are never granted until a transfer with in_last[g]=1, which returns to UNLOCKED.
//   - While locked and in_valid[g]=0, no grant is made (bubble). rr_ptr does not advance.
//  ARB_MUX_LOCK_EN undefined: in_last is ignored. Every beat is arbitrated independently.
// STRUCTURE
//  - Shared package arb_mux_pkg: function clog2_min1(int) for SEL_W.
//    Package also holds typedef enum {OUT_EMPTY,OUT_FULL} and typedef enum {UNLOCKED,LOCKED}.
//  - Sub-module rr_arbiter: N-bit request vector, pointer and mode in; one-hot grant and encoded
//    index out; purely combinational. The top level holds the pointer, lock and output registers.
// TESTING
//  1 Reset: assert reset mid-burst with out_valid=1 -> out_valid, out_data and out_sel read 0
//    without waiting for a clock edge; in_ready=0.
//  2 Fixed priority, RR_MODE=0, N=3: in_valid=3'b110, out_ready=1 ->
//    in_ready=3'b010, next cycle out_sel=1, out_data=d1.
//  3 Round-robin, N=3: all valid, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,0,1,2.
//    No channel is granted twice in a row.
//  4 Backpressure: out_valid=1, out_ready=0, in_valid=3'b111 -> in_ready=0 and out_data stable.
//    When out_ready rises, a new beat loads the same edge.
//  5 Wrap and empty: only ch2 valid with rr_ptr=2 -> grant 2, rr_ptr becomes 0.
//    Then no requests with out_ready=1 -> out_valid=0 after one cycle.
//  6 ARB_MUX_LOCK_EN: ch0 sends 3 beats with in_last=0,0,1 while ch1 is valid ->
//    out_sel=0,0,0, then 1. A gap in ch0's in_valid mid-burst yields a bubble, not a ch1 grant.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux registered arbitrating multiplexer.
package arb_mux_pkg;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
    typedef enum logic {UNLOCKED, LOCKED}    lock_state_e;

    // Select width never collapses to zero, even for a 2-channel mux.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: first request at or after ptr_i (round-robin) or from 0 (fixed priority).
module rr_arbiter #(
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             rr_mode_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    int base;
    int pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        base  = rr_mode_i ? int'(ptr_i) : 0;
        for (int k = 0; k < N; k++) begin
            pos = (base + k) % N;
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = SEL_W'(pos);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered arbitrating mux with valid/ready handshake and a one-entry output stage.
// Optional burst locking is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  N       = 3,
    parameter bit  RR_MODE = 1'b1,
    localparam int SEL_W   = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    out_state_e       out_st_q, out_st_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gidx;
    logic             gany;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] win_data;

`ifdef ARB_MUX_LOCK_EN
    lock_state_e      lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             win_last;

    // While locked, only the owning channel may request; its absence is a bubble.
    always_comb begin
        req = in_valid;
        if (lock_q == LOCKED) begin
            req = in_valid & (N'(1) << lock_ch_q);
        end
    end

    assign win_last = |(in_last & gnt);

    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            lock_d    = win_last ? UNLOCKED : LOCKED;
            lock_ch_d = gidx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= UNLOCKED;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    logic unused_last;

    assign req         = in_valid;
    assign unused_last = ^in_last;
`endif

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .rr_mode_i (RR_MODE),
        .gnt_o     (gnt),
        .idx_o     (gidx),
        .any_o     (gany)
    );

    assign load     = (out_st_q == OUT_EMPTY) || out_ready;
    assign xfer     = load && gany;
    assign in_ready = (xfer && !reset) ? gnt : '0;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_st_d   = out_st_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            if (gany) begin
                out_st_d   = OUT_FULL;
                out_data_d = win_data;
                out_sel_d  = gidx;
                rr_ptr_d   = (gidx == SEL_W'(N-1)) ? '0 : gidx + 1'b1;
            end else begin
                // Data and select keep their last values when the stage drains.
                out_st_d = OUT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_st_q   <= OUT_EMPTY;
            out_data_q <= '0;
            out_sel_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_st_q   <= out_st_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (out_st_q == OUT_FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one round-robin and one fixed-priority instance share the inputs.
module tb_arb_mux;

    localparam int WIDTH = 8;
    localparam int N     = 3;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic               out_ready;

    logic [N-1:0]       rr_in_ready, fx_in_ready;
    logic               rr_out_valid, fx_out_valid;
    logic [WIDTH-1:0]   rr_out_data, fx_out_data;
    logic [SEL_W-1:0]   rr_out_sel, fx_out_sel;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .N(N), .RR_MODE(1'b1)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_sel   (rr_out_sel),
        .out_ready (out_ready)
    );

    arb_mux #(.WIDTH(WIDTH), .N(N), .RR_MODE(1'b0)) u_fx (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (fx_in_ready),
        .out_valid (fx_out_valid),
        .out_data  (fx_out_data),
        .out_sel   (fx_out_sel),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] D0 = 8'hA0;
    localparam logic [7:0] D1 = 8'hB1;
    localparam logic [7:0] D2 = 8'hC2;

    logic [7:0] exp_d [3];
    logic [SEL_W-1:0] prev_sel;

    initial begin
        exp_d[0] = D0;
        exp_d[1] = D1;
        exp_d[2] = D2;

        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = {D2, D1, D0};
        out_ready = 1'b0;
        repeat (2) tick();

        check("rst_valid", 32'(rr_out_valid), 32'd0);
        check("rst_data",  32'(rr_out_data),  32'd0);
        check("rst_sel",   32'(rr_out_sel),   32'd0);
        reset = 1'b0;
        #1;

        // Round-robin over three always-valid channels.
        in_valid  = 3'b111;
        out_ready = 1'b1;
        #1;
        check("rr_first_ready", 32'(rr_in_ready), 32'h1);
        check("fx_first_ready", 32'(fx_in_ready), 32'h1);
        prev_sel = '1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_seq_valid", 32'(rr_out_valid), 32'd1);
            check("rr_seq_sel",   32'(rr_out_sel),   32'(k % 3));
            check("rr_seq_data",  32'(rr_out_data),  32'(exp_d[k % 3]));
            check("rr_no_repeat", 32'(rr_out_sel != prev_sel), 32'd1);
            check("fx_seq_sel",   32'(fx_out_sel),   32'd0);
            prev_sel = rr_out_sel;
        end

        // Fixed priority with channel 0 idle.
        in_valid = 3'b110;
        #1;
        check("fx_prio_ready", 32'(fx_in_ready), 32'h2);
        tick();
        check("fx_prio_sel",  32'(fx_out_sel),  32'd1);
        check("fx_prio_data", 32'(fx_out_data), 32'(D1));
        check("rr_prio_sel",  32'(rr_out_sel),  32'd1);

        // Wrap: rr pointer sits at 2, only channel 2 requests.
        in_valid = 3'b100;
        #1;
        check("wrap_ready", 32'(rr_in_ready), 32'h4);
        tick();
        check("wrap_sel",  32'(rr_out_sel),  32'd2);
        check("wrap_data", 32'(rr_out_data), 32'(D2));
        in_valid = 3'b000;
        tick();
        check("empty_valid",    32'(rr_out_valid), 32'd0);
        check("empty_fx_valid", 32'(fx_out_valid), 32'd0);
        check("empty_keep_data", 32'(rr_out_data), 32'(D2));
        check("empty_keep_sel",  32'(rr_out_sel),  32'd2);
        in_valid = 3'b101;
        #1;
        check("ptr_wrapped_ready", 32'(rr_in_ready), 32'h1);

        // Backpressure with all channels requesting.
        in_valid  = 3'b111;
        out_ready = 1'b0;
        tick();
        check("bp_load_sel",  32'(rr_out_sel),   32'd0);
        check("bp_load_vld",  32'(rr_out_valid), 32'd1);
        check("bp_ready_low", 32'(rr_in_ready),  32'h0);
        check("bp_fx_low",    32'(fx_in_ready),  32'h0);
        tick();
        check("bp_hold_data", 32'(rr_out_data),  32'(D0));
        check("bp_hold_sel",  32'(rr_out_sel),   32'd0);
        check("bp_hold_vld",  32'(rr_out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(rr_in_ready), 32'h2);
        tick();
        check("bp_nobubble_vld",  32'(rr_out_valid), 32'd1);
        check("bp_nobubble_sel",  32'(rr_out_sel),   32'd1);
        check("bp_nobubble_data", 32'(rr_out_data),  32'(D1));

        // Asynchronous reset mid-stream, checked before any clock edge.
        out_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(rr_out_valid), 32'd0);
        check("async_rst_data",  32'(rr_out_data),  32'd0);
        check("async_rst_sel",   32'(rr_out_sel),   32'd0);
        check("async_rst_ready", 32'(rr_in_ready),  32'h0);
        check("async_rst_fxrdy", 32'(fx_in_ready),  32'h0);
        tick();
        reset    = 1'b0;
        in_valid = 3'b110;
        #1;
        check("rst_ptr_ready", 32'(rr_in_ready), 32'h2);

`ifdef ARB_MUX_LOCK_EN
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 3'b011;
        in_last   = 3'b000;
        #1;
        check("lk_first_ready", 32'(rr_in_ready), 32'h1);
        tick();
        check("lk_beat0_sel", 32'(rr_out_sel), 32'd0);
        check("lk_hold_ready", 32'(rr_in_ready), 32'h1);
        tick();
        check("lk_beat1_sel", 32'(rr_out_sel), 32'd0);
        in_valid = 3'b010;
        #1;
        check("lk_gap_ready", 32'(rr_in_ready), 32'h0);
        tick();
        check("lk_gap_bubble", 32'(rr_out_valid), 32'd0);
        in_valid = 3'b011;
        in_last  = 3'b001;
        #1;
        check("lk_last_ready", 32'(rr_in_ready), 32'h1);
        tick();
        check("lk_beat2_sel", 32'(rr_out_sel), 32'd0);
        in_last = 3'b000;
        #1;
        check("lk_free_ready", 32'(rr_in_ready), 32'h2);
        tick();
        check("lk_after_sel",  32'(rr_out_sel),  32'd1);
        check("lk_after_data", 32'(rr_out_data), 32'(D1));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
